// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Two-requester write arbiter in front of an async FIFO source controller.
//   Grants one requester at a time, limits each owner to MAX_BURST
//   back-to-back bytes while the other waits, and throttles writes so that
//   FIFO occupancy plus the write already in flight stays below THRESH.
//
// Ports
//   clk_s            source-domain clock, rising edge
//   reset            synchronous, active-high
//   reqN_valid/data  requester N offers a byte
//   reqN_ready       requester N byte accepted this cycle (combinational)
//   fifo_wr_ptr      FIFO write pointer (3 bits)
//   fifo_rd_ptr      FIFO read pointer, already in clk_s domain
//   write_signal     registered write strobe to the FIFO controller
//   din              registered write data
//   grant            one-hot owner: 01 = req0, 10 = req1, 00 = none
//   fifo_full_stall  owner has data but occupancy blocks it
module fifo_write_arbiter #(
  parameter int THRESH    = 6,
  parameter int MAX_BURST = 4
) (
  input  logic       clk_s,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  input  logic [2:0] fifo_wr_ptr,
  input  logic [2:0] fifo_rd_ptr,
  output logic       write_signal,
  output logic [7:0] din,
  output logic [1:0] grant,
  output logic       fifo_full_stall
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  typedef struct packed {
    logic       vld;
    logic [7:0] data;
  } req_t;

  localparam logic [3:0] THRESH_W = 4'(THRESH);
  localparam logic [3:0] BURST_W  = 4'(MAX_BURST);

  state_t      state, state_nxt;
  logic [3:0]  burst_cnt, burst_cnt_nxt;
  logic        last_owner, last_owner_nxt;

  req_t [1:0]  req;
  logic [1:0]  req_vld;
  logic [1:0]  xfer;
  logic [2:0]  occ;
  logic [3:0]  occ_w;
  logic        space_ok;
  logic        owner;
  logic        own_vld, oth_vld;
  logic        burst_hit;
  state_t      oth_state;

  assign req[0] = '{vld: req0_valid, data: req0_data};
  assign req[1] = '{vld: req1_valid, data: req1_data};
  assign req_vld = {req[1].vld, req[0].vld};

  // 3-bit subtraction wraps mod 8; widen before adding the in-flight write
  // so 7 + 1 does not alias back to 0.
  assign occ      = fifo_wr_ptr - fifo_rd_ptr;
  assign occ_w    = {1'b0, occ} + {3'b000, write_signal};
  assign space_ok = occ_w < THRESH_W;

  assign grant      = {state == OWN1, state == OWN0};
  assign req0_ready = grant[0] & space_ok;
  assign req1_ready = grant[1] & space_ok;
  assign xfer       = req_vld & {req1_ready, req0_ready};

  // Owner index is only meaningful in OWN0/OWN1; IDLE never reads it.
  assign owner     = (state == OWN1);
  assign own_vld   = req_vld[owner];
  assign oth_vld   = req_vld[~owner];
  assign oth_state = owner ? OWN0 : OWN1;
  assign burst_hit = (|xfer) && ((burst_cnt + 4'd1) == BURST_W);

  assign fifo_full_stall = (|grant) & own_vld & ~space_ok;

  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    burst_cnt_nxt  = burst_cnt + {3'b000, |xfer};
    case (state)
      IDLE: begin
        // last_owner == 1 means req1 went last, so req0 wins the tie
        if (&req_vld)        state_nxt = last_owner ? OWN0 : OWN1;
        else if (req_vld[0]) state_nxt = OWN0;
        else if (req_vld[1]) state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        // Owner dropping valid takes precedence over a burst-limit hit;
        // without valid there is no transfer, so the limit cannot fire anyway.
        if (!own_vld) begin
          state_nxt      = oth_vld ? oth_state : IDLE;
          last_owner_nxt = owner;
        end else if (burst_hit) begin
          burst_cnt_nxt = '0;
          if (oth_vld) begin
            state_nxt      = oth_state;
            last_owner_nxt = owner;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != state) burst_cnt_nxt = '0;
  end

  always_ff @(posedge clk_s) begin
    if (reset) begin
      state        <= IDLE;
      burst_cnt    <= '0;
      last_owner   <= 1'b1;
      write_signal <= 1'b0;
      din          <= 8'h00;
    end else begin
      state        <= state_nxt;
      burst_cnt    <= burst_cnt_nxt;
      last_owner   <= last_owner_nxt;
      write_signal <= |xfer;
      if (xfer[0])      din <= req[0].data;
      else if (xfer[1]) din <= req[1].data;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;

  logic       clk_s = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic [2:0] fifo_wr_ptr, fifo_rd_ptr;
  logic       write_signal;
  logic [7:0] din;
  logic [1:0] grant;
  logic       fifo_full_stall;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb_q[$];
  int         who[$];

  fifo_write_arbiter #(.THRESH(6), .MAX_BURST(4)) dut (
    .clk_s(clk_s), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .fifo_wr_ptr(fifo_wr_ptr), .fifo_rd_ptr(fifo_rd_ptr),
    .write_signal(write_signal), .din(din), .grant(grant),
    .fifo_full_stall(fifo_full_stall)
  );

  always #5 clk_s = ~clk_s;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit hit, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // One clock: note handshakes offered before the edge into the scoreboard,
  // then after the edge compare the write strobe and data it produced.
  task automatic step();
    bit hs0, hs1;
    hs0 = !reset && req0_valid && req0_ready;
    hs1 = !reset && req1_valid && req1_ready;
    if (hs0) begin sb_q.push_back(req0_data); who.push_back(0); end
    if (hs1) begin sb_q.push_back(req1_data); who.push_back(1); end
    @(posedge clk_s); #1;
    chk("wr_strobe", write_signal, hs0 | hs1);
    if (write_signal && sb_q.size() != 0) chk("din_sb", din, sb_q.pop_front());
    if (hs0) req0_data = req0_data + 8'd1;
    if (hs1) req1_data = req1_data + 8'd1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req0_valid = 0; req1_valid = 0;
    step();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; req0_valid = 0; req1_valid = 0;
    req0_data = 8'h00; req1_data = 8'h00;
    fifo_wr_ptr = 3'd0; fifo_rd_ptr = 3'd0;
    step(); step();
    chk("rst_grant", grant, 2'b00);
    chk("rst_din", din, 8'h00);
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_ready1", req1_ready, 1'b0);

    // single requester, first byte
    reset = 0; req0_valid = 1; req0_data = 8'hA1; #1;
    chk("idle_grant", grant, 2'b00);
    chk("idle_ready0", req0_ready, 1'b0);
    step();
    chk("own0_grant", grant, 2'b01);
    chk("own0_ready", req0_ready, 1'b1);
    step();
    chk("first_din", din, 8'hA1);
    req0_valid = 0;
    step();
    chk("drop_idle", grant, 2'b00);

    // both valid: 4/4 alternation, req0 first
    do_reset();
    req0_valid = 1; req1_valid = 1; req0_data = 8'h10; req1_data = 8'h80;
    who.delete();
    for (int i = 0; i < 20; i++) step();
    chk("burst_count", who.size(), 19);
    for (int i = 0; i < 16 && i < who.size(); i++)
      chk($sformatf("burst_owner%0d", i), who[i], (i / 4) % 2);
    req0_valid = 0; req1_valid = 0;
    step(); step();

    // occupancy throttle: wr=5 rd=0
    do_reset();
    fifo_wr_ptr = 3'd5; fifo_rd_ptr = 3'd0; req0_valid = 1; req0_data = 8'h33;
    step();
    chk("occ5_ready", req0_ready, 1'b1);
    step();
    chk("occ5_ws_ready", req0_ready, 1'b0);
    chk("occ5_ws_stall", fifo_full_stall, 1'b1);
    step();
    fifo_wr_ptr = 3'd6; #1;
    chk("occ6_ready", req0_ready, 1'b0);
    chk("occ6_stall", fifo_full_stall, 1'b1);
    fifo_rd_ptr = 3'd1; #1;
    chk("rd_adv_ready", req0_ready, 1'b1);
    chk("rd_adv_stall", fifo_full_stall, 1'b0);
    req0_valid = 0;
    step();

    // wrapped pointers: wr=2 rd=5 -> occupancy 5
    fifo_wr_ptr = 3'd2; fifo_rd_ptr = 3'd5;
    do_reset();
    req1_valid = 1; req1_data = 8'h5A;
    step();
    chk("wrap_ready", req1_ready, 1'b1);
    step();
    chk("wrap_ws_ready", req1_ready, 1'b0);
    chk("wrap_ws_stall", fifo_full_stall, 1'b1);
    fifo_wr_ptr = 3'd3;
    step();
    chk("wrap_occ6_ready", req1_ready, 1'b0);
    fifo_rd_ptr = 3'd6; #1;
    chk("wrap_rd_ready", req1_ready, 1'b1);
    req1_valid = 0;
    step();

    // wr=1 rd=7 -> occupancy 2, plenty of space even with a write in flight
    fifo_wr_ptr = 3'd1; fifo_rd_ptr = 3'd7;
    req0_valid = 1; req0_data = 8'h20;
    step(); step();
    chk("wrap2_ready", req0_ready, 1'b1);
    req0_valid = 0;
    step();
    fifo_wr_ptr = 3'd0; fifo_rd_ptr = 3'd0;

    // req1 drops mid-burst, req0 takes over with a fresh burst count
    do_reset();
    req1_valid = 1; req1_data = 8'h30;
    step(); step();
    req0_valid = 1; req0_data = 8'h40;
    step();
    req1_valid = 0; #1;
    chk("handoff_pre", grant, 2'b10);
    step();
    chk("handoff_post", grant, 2'b01);
    chk("handoff_ready", req0_ready, 1'b1);
    req1_valid = 1;
    who.delete();
    for (int i = 0; i < 6; i++) step();
    chk("handoff_count", who.size(), 6);
    for (int i = 0; i < 6 && i < who.size(); i++)
      chk($sformatf("handoff_owner%0d", i), who[i], (i < 4) ? 0 : 1);
    req0_valid = 0; req1_valid = 0;
    step(); step();

    // reset mid-burst with a transfer pending
    do_reset();
    req0_valid = 1; req0_data = 8'h77;
    step(); step();
    chk("pre_rst_din", din, 8'h77);
    reset = 1;
    step();
    chk("midrst_ws", write_signal, 1'b0);
    chk("midrst_grant", grant, 2'b00);
    chk("midrst_din", din, 8'h00);
    reset = 0; #1;
    chk("post_rst_ready", req0_ready, 1'b0);
    req0_valid = 0;
    step();

    chk("sb_left", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter THRESH, default 6, SHALL set the FIFO occupancy limit; a write is issued only while occupancy plus in-flight writes is below it (range 1..7).
REQ-002 Parameter MAX_BURST, default 4, SHALL set the maximum consecutive transfers granted to one requester while the other requester waits (range 1..15).
REQ-003 clk_s  input  1  source-domain clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 has a byte to write.
REQ-006 req0_data  input  8  requester 0 byte.
REQ-007 req0_ready  output  1  requester 0 transfer accepted this cycle (combinational).
REQ-008 req1_valid / req1_data / req1_ready  SHALL mirror REQ-005..007 for requester 1.
REQ-009 fifo_wr_ptr  input  3  write pointer from the FIFO source controller.
REQ-010 fifo_rd_ptr  input  3  read pointer, already synchronized into clk_s.
REQ-011 write_signal  output  1  registered write strobe to the FIFO source controller.
REQ-012 din  output  8  registered write data to the FIFO source controller.
REQ-013 grant  output  2  current owner, one-hot: 01 = req0, 10 = req1, 00 = none.
REQ-014 fifo_full_stall  output  1  owner is valid but blocked by occupancy.

Function
REQ-015 occupancy SHALL be (fifo_wr_ptr - fifo_rd_ptr) mod 8; space_ok SHALL be (occupancy + write_signal) < THRESH, evaluated at 4-bit width so that no wrap occurs.
REQ-016 The FSM SHALL have the states IDLE (grant=00), OWN0 (grant=01) and OWN1 (grant=10); grant SHALL be decoded from the state.
REQ-017 reqN_ready SHALL be grant[N] & space_ok; a transfer occurs when reqN_valid & reqN_ready are both high in the same cycle.
REQ-018 On a transfer, at the next edge write_signal SHALL be 1 and din SHALL equal reqN_data; otherwise write_signal SHALL be 0 and din SHALL hold its value.
REQ-019 Throughput SHALL be one byte per cycle while space_ok holds; latency from transfer to the write_signal pulse SHALL be 1 cycle.
REQ-020 In IDLE with both requesters valid, the next state SHALL be the owner other than last_owner; with one requester valid, the next state SHALL be that requester's OWN state; with none valid, the FSM SHALL stay in IDLE. IDLE never asserts ready, so arbitration costs 1 cycle.
REQ-021 In OWNn with reqN_valid low, the next state SHALL be OWNother if the other requester is valid, else IDLE; last_owner SHALL become n.
REQ-022 burst_cnt (4 bits) SHALL increment on each transfer in OWNn; a stalled cycle SHALL NOT count.
REQ-023 When a transfer makes burst_cnt reach MAX_BURST: if the other requester is valid, the FSM SHALL go to OWNother; otherwise it SHALL stay in OWNn; in both cases burst_cnt SHALL clear.
REQ-024 burst_cnt SHALL clear on every change of state.
REQ-025 fifo_full_stall SHALL be (grant != 00) & valid of the owner & !space_ok.
REQ-026 Pointer wrap (e.g. wr=1, rd=7 gives occupancy 2) SHALL be handled by the mod-8 subtraction only.
REQ-027 Simultaneous events: a burst limit and owner valid dropping in the same cycle SHALL follow REQ-021.
REQ-028 Data SHALL never be duplicated or lost across grant switches.

Reset
REQ-029 While reset is high at an edge: state SHALL go to IDLE, write_signal to 0, din to 8'h00, burst_cnt to 0 and last_owner to 1, so req0 wins the first tie.
REQ-030 Reset SHALL have priority over all transfers; a transfer in the reset cycle SHALL be discarded, and ready SHALL be 0 in the cycle after reset.
REQ-031 Reset asserted mid-burst SHALL give write_signal = 0 at the next edge, with no partial write.

Verification
REQ-032 Reset, then req0_valid only with data 8'hA1, pointers 0/0 -> grant=01 after 1 cycle, then write_signal=1, din=A1 one cycle after the transfer.
REQ-033 Both requesters valid continuously, MAX_BURST=4, FIFO drained -> 4 req0 bytes, switch to OWN1, 4 req1 bytes, alternating; first owner is req0.
REQ-034 Pointers wr=5, rd=0 with write_signal=1 -> ready=0 and fifo_full_stall=1; advance rd to 1 -> ready returns to 1.
REQ-035 Pointers wr=2, rd=5 (occupancy 5), single write -> next cycle space_ok=0 until rd advances (THRESH=6 wrap check).
REQ-036 req1 drops valid mid-burst while req0 is valid -> grant goes 10 -> 01 with no IDLE cycle, and burst_cnt=0.
REQ-037 Assert reset during OWN0 with a transfer pending -> next edge write_signal=0, grant=00 and din=00.
